// File: rtl/ttc_trigger_processor.sv
// Trigger-info consumer for the TTC trigger FIFO: unpacks one word, checks
// trigger-number and event-count continuity, and hands it to readout.
//
// state     | meaning
// IDLE      | fifo_ready high, waiting for a trigger word
// REQUEST   | rdo_req high, waiting for rdo_ack
// WAIT_DONE | request accepted, waiting for rdo_done
// ERROR     | ack/done timed out; held until reset
module ttc_trigger_processor #(
  parameter int TIMEOUT = 40000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reset_trig_num,
  input  logic         fifo_valid,
  input  logic [127:0] fifo_data,
  output logic         fifo_ready,
  output logic         rdo_req,
  input  logic         rdo_ack,
  input  logic         rdo_done,
  output logic [23:0]  rdo_trig_num,
  output logic [23:0]  rdo_event_cnt,
  output logic [4:0]   rdo_trig_type,
  output logic [43:0]  rdo_timestamp,
  output logic         rdo_empty_event,
  output logic         rdo_empty_payload,
  output logic [3:0]   rdo_xadc_alarms,
  output logic [3:0]   state,
  output logic [31:0]  processed_count,
  output logic         error_trig_num_skip,
  output logic         error_event_cnt_skip,
  output logic         error_timeout
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0001,
    S_REQUEST   = 4'b0010,
    S_WAIT_DONE = 4'b0100,
    S_ERROR     = 4'b1000
  } state_t;

  state_t        st;
  logic [TW-1:0] tmr;
  logic [23:0]   exp_trig_num;
  logic [23:0]   exp_event_cnt;

  logic [43:0] w_timestamp;
  logic [23:0] w_trig_num;
  logic [23:0] w_event_cnt;
  logic [4:0]  w_trig_type;
  logic        w_empty_event;
  logic [3:0]  w_xadc_alarms;
  logic        w_empty_payload;
  logic        unused_bits;

  assign w_timestamp     = fifo_data[43:0];
  assign w_trig_num      = fifo_data[67:44];
  assign w_event_cnt     = fifo_data[91:68];
  assign w_trig_type     = fifo_data[96:92];
  assign w_empty_event   = fifo_data[97];
  assign w_xadc_alarms   = fifo_data[101:98];
  assign w_empty_payload = fifo_data[102];
  assign unused_bits     = ^fifo_data[127:103];

  assign state         = st;
  assign fifo_ready    = (st == S_IDLE);
  assign rdo_req       = (st == S_REQUEST);
  assign error_timeout = (st == S_ERROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      st                   <= S_IDLE;
      tmr                  <= '0;
      exp_trig_num         <= 24'd1;
      exp_event_cnt        <= 24'd1;
      rdo_trig_num         <= '0;
      rdo_event_cnt        <= '0;
      rdo_trig_type        <= '0;
      rdo_timestamp        <= '0;
      rdo_empty_event      <= 1'b0;
      rdo_empty_payload    <= 1'b0;
      rdo_xadc_alarms      <= '0;
      processed_count      <= '0;
      error_trig_num_skip  <= 1'b0;
      error_event_cnt_skip <= 1'b0;
    end else begin
      // A word accepted in the same cycle skips its checks, so this stands.
      if (reset_trig_num) begin
        exp_trig_num  <= 24'd1;
        exp_event_cnt <= 24'd1;
      end
      case (st)
        S_IDLE: begin
          if (fifo_valid) begin
            rdo_trig_num      <= w_trig_num;
            rdo_event_cnt     <= w_event_cnt;
            rdo_trig_type     <= w_trig_type;
            rdo_timestamp     <= w_timestamp;
            rdo_empty_event   <= w_empty_event;
            rdo_empty_payload <= w_empty_payload;
            rdo_xadc_alarms   <= w_xadc_alarms;
            if (!reset_trig_num) begin
              if (w_trig_num != exp_trig_num) error_trig_num_skip <= 1'b1;
              exp_trig_num <= w_trig_num + 24'd1;
              if (w_event_cnt != exp_event_cnt) error_event_cnt_skip <= 1'b1;
              exp_event_cnt <= w_empty_event ? w_event_cnt : w_event_cnt + 24'd1;
            end
            tmr <= '0;
            st  <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (rdo_ack) begin
            tmr <= '0;
            st  <= S_WAIT_DONE;
          end else if (tmr == TMR_LAST) begin
            st <= S_ERROR;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (rdo_done) begin
            processed_count <= processed_count + 32'd1;
            st              <= S_IDLE;
          end else if (tmr == TMR_LAST) begin
            st <= S_ERROR;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_ERROR: st <= S_ERROR;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
